// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants.
// Reset PC, fetch FSM encoding, extender modes, IF/ID bundle.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFF;

  localparam logic [3:0] EXT_ZERO  = 4'd0;
  localparam logic [3:0] EXT_SIGN  = 4'd1;
  localparam logic [3:0] EXT_UPPER = 4'd2;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [15:0] imm;
    logic [3:0]  ext_sel;
  } if_id_t;

endpackage

// File: rtl/ext_sel_dec.sv
// ext_sel_dec: opcode to immediate-extender mode.
// Logical-immediate ops zero-extend, lui shifts up, rest sign-extend.
module ext_sel_dec
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  output logic [3:0] sel
);

  // Opcode classification
  always_comb begin
    sel = EXT_SIGN;
    unique case (1'b1)
      (op inside {6'h0C, 6'h0D, 6'h0E}): sel = EXT_ZERO;
      (op == 6'h0F):                     sel = EXT_UPPER;
      default:                           sel = EXT_SIGN;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch FSM and IF/ID register with delay-slot redirect.
// Optional fetch address check enabled by macro IF_ADEL_CHECK_EN.
module if_id_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic [15:0] id_imm,
  output logic [3:0]  id_ext_sel
`ifdef IF_ADEL_CHECK_EN
  ,
  output logic        id_exc_adel
`endif
);

  if_state_e   state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pend, pend_nx;
  logic        pend_v, pend_v_nx;
  logic        drop, drop_nx;
  logic [31:0] hbuf;
  logic        buf_we;
  logic        load;
  logic [31:0] word;
  logic [3:0]  ext;
  logic        adel;
  if_id_t      ifid;

`ifdef IF_ADEL_CHECK_EN
  assign adel = (pc[1:0] != 2'b00)
             || (pc < IMEM_LO)
             || (pc > IMEM_HI);
`else
  assign adel = 1'b0;
`endif

  assign imem_req  = (state == S_REQ) && !adel;
  assign imem_addr = pc;

  ext_sel_dec u_dec (
    .op  (word[31:26]),
    .sel (ext)
  );

  // Next state, next pc, redirect and drop bookkeeping
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    pend_nx   = pend;
    pend_v_nx = pend_v;
    drop_nx   = drop;
    buf_we    = 1'b0;
    load      = 1'b0;
    word      = imem_rdata;
    if (flush) begin
      pc_nx     = flush_pc;
      pend_v_nx = 1'b0;
      unique case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            state_nx = S_WAIT;
            drop_nx  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_nx = S_REQ;
            drop_nx  = 1'b0;
          end else begin
            drop_nx = 1'b1;
          end
        end
        S_HOLD:  state_nx = S_REQ;
        default: state_nx = S_REQ;
      endcase
    end else begin
      if (br_taken && !stall) begin
        pend_nx   = br_target;
        pend_v_nx = 1'b1;
      end
      unique case (state)
        S_REQ: begin
          if (adel && !stall) begin
            load = 1'b1;
            word = '0;
          end else if (imem_req && imem_gnt) begin
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_nx  = 1'b0;
              state_nx = S_REQ;
            end else if (stall) begin
              buf_we   = 1'b1;
              state_nx = S_HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load = 1'b1;
            word = hbuf;
          end
        end
        default: state_nx = S_REQ;
      endcase
      if (load) begin
        state_nx  = S_REQ;
        pend_v_nx = 1'b0;
        if (br_taken && !stall)
          pc_nx = br_target;
        else if (pend_v)
          pc_nx = pend;
        else
          pc_nx = pc + 32'd4;
      end
    end
  end

  // Fetch control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      pend   <= '0;
      pend_v <= 1'b0;
      drop   <= 1'b0;
      hbuf   <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      pend   <= pend_nx;
      pend_v <= pend_v_nx;
      drop   <= drop_nx;
      if (buf_we)
        hbuf <= imem_rdata;
    end
  end

  // IF/ID pipeline register: load, hold on stall, else bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid.valid   <= 1'b0;
      ifid.instr   <= '0;
      ifid.pc      <= '0;
      ifid.pc8     <= 32'h0000_0008;
      ifid.imm     <= '0;
      ifid.ext_sel <= EXT_ZERO;
    end else if (flush) begin
      ifid.valid <= 1'b0;
    end else if (load) begin
      ifid.valid   <= 1'b1;
      ifid.instr   <= word;
      ifid.pc      <= pc;
      ifid.pc8     <= pc + 32'd8;
      ifid.imm     <= word[15:0];
      ifid.ext_sel <= ext;
    end else if (!stall) begin
      ifid.valid <= 1'b0;
    end
  end

`ifdef IF_ADEL_CHECK_EN
  // Address-error flag travels with the IF/ID word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      id_exc_adel <= 1'b0;
    else if (flush)
      id_exc_adel <= 1'b0;
    else if (load)
      id_exc_adel <= (state == S_REQ);
    else if (!stall)
      id_exc_adel <= 1'b0;
  end
`endif

  assign id_valid   = ifid.valid;
  assign id_instr   = ifid.instr;
  assign id_pc      = ifid.pc;
  assign id_pc8     = ifid.pc8;
  assign id_imm     = ifid.imm;
  assign id_ext_sel = ifid.ext_sel;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed bench for if_id_stage.
// Memory returns 0x2400_<addr[15:0]> except two hand-placed words.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic [15:0] id_imm;
  logic [3:0]  id_ext_sel;
`ifdef IF_ADEL_CHECK_EN
  logic        id_exc_adel;
`endif

  int          n_cmp;
  int          n_bad;
  int          dly;
  logic [31:0] ra;
  logic [31:0] req_q[$];

  if_id_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8),
    .id_imm      (id_imm),
    .id_ext_sel  (id_ext_sel)
`ifdef IF_ADEL_CHECK_EN
    ,
    .id_exc_adel (id_exc_adel)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_3020: return 32'h3C01_ABCD;
      32'h0000_3024: return 32'h3421_FFFF;
      default:       return {16'h2400, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_vld(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (id_valid) break;
    end
    chk({tag, "_vld"}, {31'b0, id_valid}, 32'd1);
  endtask

  task automatic exp_req(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (req_q.size() != 0) got = req_q.pop_front();
    chk(tag, got, exp);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    imem_gnt = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;
    flush    = 1'b0;
    dly      = 0;
    repeat (4) cyc();
    req_q.delete();
  endtask

  // Accepted-request log
  always @(negedge clk)
    if (reset_n && imem_req && imem_gnt)
      req_q.push_back(imem_addr);

  // Memory responder: one response per accepted request
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && imem_req && imem_gnt) begin
        ra = imem_addr;
        @(posedge clk);
        #1;
        repeat (dly) begin
          @(posedge clk);
          #1;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem(ra);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    br_target = '0;
    flush_pc  = '0;
    do_reset();

    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc8", id_pc8, 32'h8);
    chk("rst_imm", {16'b0, id_imm}, 32'h0);
    chk("rst_ext", {28'b0, id_ext_sel}, 32'h0);
    chk("rst_addr", imem_addr, 32'h3000);
`ifdef IF_ADEL_CHECK_EN
    chk("rst_adel", {31'b0, id_exc_adel}, 32'd0);
`endif

    // sequential fetch, grant withheld for two cycles
    reset_n = 1'b1;
    @(negedge clk);
    chk("gnt0_req", {31'b0, imem_req}, 32'd1);
    chk("gnt0_addr", imem_addr, 32'h3000);
    cyc();
    @(negedge clk);
    chk("gnt0_addr2", imem_addr, 32'h3000);
    cyc();
    imem_gnt = 1'b1;
    wait_vld("s1a", 10);
    chk("s1a_pc", id_pc, 32'h3000);
    chk("s1a_instr", id_instr, 32'h2400_3000);
    chk("s1a_pc8", id_pc8, 32'h3008);
    chk("s1a_imm", {16'b0, id_imm}, 32'h3000);
    chk("s1a_ext", {28'b0, id_ext_sel}, 32'd1);
    wait_vld("s1b", 10);
    chk("s1b_pc", id_pc, 32'h3004);
    chk("s1b_pc8", id_pc8, 32'h300C);
    wait_vld("s1c", 10);
    chk("s1c_pc", id_pc, 32'h3008);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_pc8", id_pc8, 32'h8);
    chk("arst_addr", imem_addr, 32'h3000);
    exp_req("s1_req0", 32'h3000);
    exp_req("s1_req1", 32'h3004);
    exp_req("s1_req2", 32'h3008);

    // stall across a response
    do_reset();
    imem_gnt = 1'b1;
    reset_n  = 1'b1;
    wait_vld("s2a", 10);
    chk("s2a_pc", id_pc, 32'h3000);
    stall = 1'b1;
    @(negedge clk);
    chk("s2_hold1_v", {31'b0, id_valid}, 32'd1);
    chk("s2_hold1_pc", id_pc, 32'h3000);
    @(negedge clk);
    chk("s2_hold2_req", {31'b0, imem_req}, 32'd0);
    chk("s2_hold2_pc", id_pc, 32'h3000);
    cyc();
    stall = 1'b0;
    @(negedge clk);
    chk("s2_hold3_pc", id_pc, 32'h3000);
    chk("s2_hold3_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("s2b_vld", {31'b0, id_valid}, 32'd1);
    chk("s2b_pc", id_pc, 32'h3004);
    chk("s2b_instr", id_instr, 32'h2400_3004);
    cyc();
    exp_req("s2_req0", 32'h3000);
    exp_req("s2_req1", 32'h3004);
    exp_req("s2_req2", 32'h3008);

    // taken branch at 0x3010 with delay slot
    do_reset();
    imem_gnt = 1'b1;
    reset_n  = 1'b1;
    for (int k = 0; k < 5; k++)
      wait_vld("s3seq", 10);
    chk("s3_br_pc", id_pc, 32'h3010);
    br_taken  = 1'b1;
    br_target = 32'h3100;
    cyc();
    br_taken = 1'b0;
    wait_vld("s3ds", 10);
    chk("s3_ds_pc", id_pc, 32'h3014);
    wait_vld("s3tg", 10);
    chk("s3_tg_pc", id_pc, 32'h3100);
    cyc();
    for (int k = 0; k < 5; k++)
      exp_req("s3_seq", 32'h3000 + 32'(4 * k));
    exp_req("s3_ds_req", 32'h3014);
    exp_req("s3_tg_req", 32'h3100);

    // flush while waiting on a slow response
    do_reset();
    dly      = 2;
    imem_gnt = 1'b1;
    reset_n  = 1'b1;
    cyc();
    flush    = 1'b1;
    flush_pc = 32'h4180;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("s4_w1_req", {31'b0, imem_req}, 32'd0);
    chk("s4_w1_v", {31'b0, id_valid}, 32'd0);
    @(negedge clk);
    chk("s4_w2_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("s4_req", {31'b0, imem_req}, 32'd1);
    chk("s4_addr", imem_addr, 32'h4180);
    chk("s4_v", {31'b0, id_valid}, 32'd0);
    wait_vld("s4", 20);
    chk("s4_pc", id_pc, 32'h4180);
    chk("s4_instr", id_instr, 32'h2400_4180);
    cyc();
    exp_req("s4_req0", 32'h3000);
    exp_req("s4_req1", 32'h4180);

    // extender mode for lui and ori
    do_reset();
    imem_gnt = 1'b1;
    reset_n  = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h3020;
    cyc();
    flush = 1'b0;
    wait_vld("s5lui", 10);
    chk("s5_lui_pc", id_pc, 32'h3020);
    chk("s5_lui_instr", id_instr, 32'h3C01_ABCD);
    chk("s5_lui_imm", {16'b0, id_imm}, 32'hABCD);
    chk("s5_lui_ext", {28'b0, id_ext_sel}, 32'd2);
    wait_vld("s5ori", 10);
    chk("s5_ori_instr", id_instr, 32'h3421_FFFF);
    chk("s5_ori_imm", {16'b0, id_imm}, 32'hFFFF);
    chk("s5_ori_ext", {28'b0, id_ext_sel}, 32'd0);

`ifndef IF_ADEL_CHECK_EN
    // pc wraps past the top of the address space
    do_reset();
    imem_gnt = 1'b1;
    reset_n  = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    cyc();
    flush = 1'b0;
    wait_vld("s6", 10);
    chk("s6_pc", id_pc, 32'hFFFF_FFFC);
    chk("s6_pc8", id_pc8, 32'h0000_0004);
    cyc();
    exp_req("s6_req0", 32'h3000);
    exp_req("s6_req1", 32'hFFFF_FFFC);
    exp_req("s6_req2", 32'h0000_0000);
`else
    // misaligned redirect raises address error, no request
    do_reset();
    imem_gnt = 1'b1;
    reset_n  = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h3002;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("s7_addr", imem_addr, 32'h3002);
    chk("s7_req", {31'b0, imem_req}, 32'd0);
    wait_vld("s7", 10);
    chk("s7_pc", id_pc, 32'h3002);
    chk("s7_instr", id_instr, 32'h0);
    chk("s7_adel", {31'b0, id_exc_adel}, 32'd1);
    cyc();
    exp_req("s7_req0", 32'h3000);
    chk("s7_noreq", 32'(req_q.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports imem_req (output, 1, fetch request valid), imem_addr (output, 32, byte PC) and imem_gnt (input, 1, request accepted).
REQ-004 SHALL have ports imem_rvalid (input, 1, response valid) and imem_rdata (input, 32, instruction word).
REQ-005 SHALL have ports stall (input, 1, hazard hold), br_taken (input, 1, ID-stage redirect) and br_target (input, 32, redirect PC).
REQ-006 SHALL have ports flush (input, 1, exception flush) and flush_pc (input, 32, handler PC).
REQ-007 SHALL have outputs id_valid (1), id_instr (32), id_pc (32) and id_pc8 (32, id_pc+8).
REQ-008 SHALL have outputs id_imm (16, id_instr[15:0]) and id_ext_sel (4, extender mode: 0 zero, 1 sign, 2 upper).

Function
REQ-009 SHALL run a 3-state FSM: S_REQ (imem_req=1), S_WAIT (awaiting imem_rvalid) and S_HOLD (word captured, IF/ID blocked by stall).
REQ-010 SHALL move S_REQ->S_WAIT when imem_gnt=1, with imem_addr held stable while imem_req=1 and imem_gnt=0.
REQ-011 SHALL, in S_WAIT on imem_rvalid with stall=0, load IF/ID, set id_valid=1, advance pc and return to S_REQ; with stall=1, buffer the word and go to S_HOLD.
REQ-012 SHALL clear id_valid for every cycle in which no new word is loaded and stall=0 (bubble insertion).
REQ-013 SHALL, while stall=1, hold every IF/ID output and pc unchanged.
REQ-014 SHALL leave S_HOLD on the first cycle with stall=0, load the buffered word into IF/ID and return to S_REQ.
REQ-015 SHALL keep at most one imem request outstanding.
REQ-016 SHALL use pc+4 as next pc, wrapping modulo 2^32.
REQ-017 SHALL honour the branch delay slot: on br_taken with stall=0, latch br_target into a pending-redirect register; the fetch in flight or next completed (the delay slot) keeps sequential pc; pc becomes the target after the delay slot is loaded.
REQ-018 SHALL ignore br_taken while stall=1.
REQ-019 SHALL give flush priority over stall and br_taken: id_valid=0, pending redirect cleared, pc=flush_pc on the next edge, and any in-flight response discarded when it arrives (drop flag), with no IF/ID load.
REQ-020 SHALL compute id_ext_sel from imem_rdata[31:26] at capture: 0x0C/0x0D/0x0E->0, 0x0F->2, otherwise 1.

Reset
REQ-021 SHALL, on reset_n=0, immediately force pc=0x0000_3000, state S_REQ, id_valid=0, id_instr/id_pc/id_imm=0, id_pc8=0x0000_0008, id_ext_sel=0, and clear the pending redirect and drop flag.
REQ-022 SHALL, on reset mid-transaction, abandon the outstanding request and ignore any imem_rvalid arriving in the first cycle after release.

Configuration
REQ-023 SHALL, with IF_ADEL_CHECK_EN defined, add output id_exc_adel (1) set when the fetched pc[1:0]!=0 or pc lies outside 0x0000_3000-0x0000_6FFF; no imem request is issued for such a pc, and id_instr=0 with id_valid=1.
REQ-024 SHALL, without IF_ADEL_CHECK_EN, omit the id_exc_adel port and the check logic entirely.

Structure
REQ-025 SHALL place the reset PC, the FSM state encoding and the EXT_ZERO/EXT_SIGN/EXT_UPPER constants in shared package cpu_pkg.
REQ-026 SHALL place the opcode-to-id_ext_sel decode in sub-module ext_sel_dec.

Verification
REQ-027 SHALL cover reset release with imem_gnt=1 and 1-cycle rvalid: addresses 0x3000, 0x3004, 0x3008 are issued, and id_pc follows one response later.
REQ-028 SHALL cover stall=1 for 3 cycles while a response arrives: IF/ID is held, S_HOLD is entered, and on stall release the buffered word appears with no re-fetch.
REQ-029 SHALL cover beq at 0x3010 with br_taken and target 0x3100: 0x3014 is fetched (delay slot), then 0x3100.
REQ-030 SHALL cover flush with flush_pc=0x4180 during S_WAIT: the late response is dropped, id_valid=0, and the next imem_addr is 0x4180.
REQ-031 SHALL cover instr 0x3C01ABCD (lui): id_imm=0xABCD, id_ext_sel=2; and ori 0x3421FFFF: id_ext_sel=0.
REQ-032 SHALL cover, with IF_ADEL_CHECK_EN, a redirect to 0x3002: id_exc_adel=1 and no imem_req is raised for that pc.
